cla_pipe_addsub: RTL



---
 rtl/cla_pkg.sv | 19 +
 rtl/cla_group_unit.sv | 55 +++++
 rtl/cla_pipe_addsub.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared constants and configuration helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam int CLA_WIDTH = 32;
  localparam int CLA_GROUP = 4;

  function automatic int cla_ngroups(input int width, input int group);
    return width / group;
  endfunction

  // Legal when WIDTH splits into whole groups and the groups split evenly across stages.
  function automatic bit cla_cfg_ok(input int width, input int group, input int stages);
    int ng;
    if (group < 1 || width < group || (width % group) != 0) return 1'b0;
    ng = width / group;
    return (stages >= 1) && (stages <= ng) && ((ng % stages) == 0);
  endfunction

endpackage

// File: rtl/cla_group_unit.sv
// GROUP-bit lookahead cell: local sum plus group generate/propagate for the slice-level lookahead.
module cla_group_unit
  import cla_pkg::*;
#(
  parameter int GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] sum,
  output logic             g,
  output logic             p
);

  logic [GROUP-1:0] bit_g;
  logic [GROUP-1:0] bit_p;
  logic [GROUP-1:0] c;

  assign bit_g = a & b;
  assign bit_p = a ^ b;

  // Flat sum-of-products carries: no bit waits on its neighbour's carry.
  always_comb begin
    logic term;
    logic acc;
    c = '0;
    for (int j = 0; j < GROUP; j++) begin
      term = ci;
      for (int m = 0; m < j; m++) term = term & bit_p[m];
      acc = term;
      for (int k = 0; k < j; k++) begin
        term = bit_g[k];
        for (int m = k + 1; m < j; m++) term = term & bit_p[m];
        acc = acc | term;
      end
      c[j] = acc;
    end
  end

  always_comb begin
    logic term;
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < GROUP; k++) begin
      term = bit_g[k];
      for (int m = k + 1; m < GROUP; m++) term = term & bit_p[m];
      acc = acc | term;
    end
    g = acc;
  end

  assign p   = &bit_p;
  assign sum = bit_p ^ c;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Optional status flags (ovf_o, zero_o, neg_o) are built when CLA_PIPE_FLAGS_EN is defined.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = CLA_WIDTH,
  parameter int GROUP  = CLA_GROUP,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef CLA_PIPE_FLAGS_EN
  ,
  output logic             ovf_o,
  output logic             zero_o,
  output logic             neg_o
`endif
);

  localparam int NGROUPS = cla_ngroups(WIDTH, GROUP);
  localparam int GPS     = NGROUPS / STAGES;
  localparam int SW      = GPS * GROUP;
  localparam int LAST    = STAGES - 1;

  if (!cla_cfg_ok(WIDTH, GROUP, STAGES)) begin : g_cfg_err
    $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP and STAGES must divide WIDTH/GROUP");
  end

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [STAGES-1:0] advance;

  logic             valid_reg [STAGES];
  logic [WIDTH-1:0] a_reg     [STAGES];
  logic [WIDTH-1:0] b_reg     [STAGES];
  logic [WIDTH-1:0] sum_reg   [STAGES];
  logic             c_reg     [STAGES];

  assign b_eff = sub_i ? ~b_i : b_i;
  assign c0    = sub_i ? 1'b1 : cin_i;

  // Walk from the output back so each stage sees whether its successor frees up this cycle.
  always_comb begin
    logic nxt_free;
    logic adv;
    advance  = '0;
    nxt_free = out_ready_i;
    for (int s = STAGES - 1; s >= 0; s--) begin
      adv        = valid_reg[s] & nxt_free;
      advance[s] = adv;
      nxt_free   = !valid_reg[s] | adv;
    end
  end

  assign in_ready_o = !valid_reg[0] | advance[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * SW;

    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_sum;
    logic             in_c;
    logic             load;
    logic [GPS-1:0]   grp_g;
    logic [GPS-1:0]   grp_p;
    logic [GPS-1:0]   grp_c;
    logic [SW-1:0]    grp_sum;
    logic [GPS:0]     lc;
    logic [WIDTH-1:0] sum_next;

    if (gi == 0) begin : g_src
      assign in_a   = a_i;
      assign in_b   = b_eff;
      assign in_sum = '0;
      assign in_c   = c0;
      assign load   = in_valid_i & in_ready_o;
    end else begin : g_src
      assign in_a   = a_reg[gi-1];
      assign in_b   = b_reg[gi-1];
      assign in_sum = sum_reg[gi-1];
      assign in_c   = c_reg[gi-1];
      assign load   = advance[gi-1];
    end

    for (genvar gj = 0; gj < GPS; gj++) begin : g_grp
      cla_group_unit #(.GROUP(GROUP)) u_grp (
        .a   (in_a[LO + gj*GROUP +: GROUP]),
        .b   (in_b[LO + gj*GROUP +: GROUP]),
        .ci  (grp_c[gj]),
        .sum (grp_sum[gj*GROUP +: GROUP]),
        .g   (grp_g[gj]),
        .p   (grp_p[gj])
      );
    end

    // Second lookahead level across the slice; lc[GPS] is the carry handed to the next stage.
    always_comb begin
      logic term;
      logic acc;
      lc = '0;
      for (int j = 0; j <= GPS; j++) begin
        term = in_c;
        for (int m = 0; m < j; m++) term = term & grp_p[m];
        acc = term;
        for (int k = 0; k < j; k++) begin
          term = grp_g[k];
          for (int m = k + 1; m < j; m++) term = term & grp_p[m];
          acc = acc | term;
        end
        lc[j] = acc;
      end
    end

    assign grp_c = lc[GPS-1:0];

    always_comb begin
      sum_next            = in_sum;
      sum_next[LO +: SW]  = grp_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg[gi] <= 1'b0;
        a_reg[gi]     <= '0;
        b_reg[gi]     <= '0;
        sum_reg[gi]   <= '0;
        c_reg[gi]     <= 1'b0;
      end else if (load) begin
        valid_reg[gi] <= 1'b1;
        a_reg[gi]     <= in_a;
        b_reg[gi]     <= in_b;
        sum_reg[gi]   <= sum_next;
        c_reg[gi]     <= lc[GPS];
      end else if (advance[gi]) begin
        valid_reg[gi] <= 1'b0;
      end
    end

`ifdef CLA_PIPE_FLAGS_EN
    if (gi == LAST) begin : g_flags
      logic msb_cin;
      logic ovf_reg;
      logic zero_reg;
      logic neg_reg;

      // Carry into the MSB recovered from its sum bit, given the operand bits.
      assign msb_cin = in_a[WIDTH-1] ^ in_b[WIDTH-1] ^ sum_next[WIDTH-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_reg  <= 1'b0;
          zero_reg <= 1'b0;
          neg_reg  <= 1'b0;
        end else if (load) begin
          ovf_reg  <= msb_cin ^ lc[GPS];
          zero_reg <= (sum_next == '0);
          neg_reg  <= sum_next[WIDTH-1];
        end
      end

      assign ovf_o  = ovf_reg;
      assign zero_o = zero_reg;
      assign neg_o  = neg_reg;
    end
`endif
  end

  assign out_valid_o = valid_reg[LAST];
  assign sum_o       = sum_reg[LAST];
  assign cout_o      = c_reg[LAST];

endmodule
